id_stage_queue: RTL and testbench
=================================

// Module: id_stage_queue
// PURPOSE
//  MIPS decode stage with a DEPTH-entry instruction queue on the fetch side and a registered
//  decoded bundle on the EX side, valid/ready handshakes on both. Adds a load-use interlock,
//  illegal-instruction flagging, branch-target computation and flush. Sits between IF and EX.
// PARAMETERS
//  DEPTH     4   instruction queue entries; power of two, >= 2
//  PC_W      32  program counter width
//  LU_STALL  1   1: insert one bubble on load-use hazard; 0: no interlock (EX forwards)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  flush      in   1      discard queue contents and output bundle
//  in_valid   in   1      fetch offers {in_ins, in_pc}
//  in_ready   out  1      queue can accept (count < DEPTH)
//  in_ins     in   32     instruction word
//  in_pc      in   PC_W   pc of in_ins
//  out_valid  out  1      decoded bundle valid
//  out_ready  in   1      EX accepts bundle
//  out_pc     out  PC_W   pc of bundle
//  rd_addr_a  out  5      rs;  rd_addr_b  out 5  rt
//  wr_addr    out  5      dest register (rd / rt / 31)
//  reg_wr     out  1      register write enable
//  mem_rd     out  1      load;  mem_wr  out 1  store
//  aluop      out  aluop_t  ALU operation (MIPS_DEF)
//  sign       out  1      signed compare/shift
//  ext_imm    out  32     extended immediate, or shamt for R-type
//  use_imm    out  1      ALU operand B is ext_imm
//  jump       out  1      J/JAL;  jump_pc  out PC_W  {pc[PC_W-1:28], addr26, 2'b00}
//  branch     out  2      00 none, 01 jr, 10 beq, 11 bne
//  branch_pc  out  PC_W   pc + 4 + (sign-extended imm << 2)
//  illegal    out  1      unsupported opcode/func
// BEHAVIOUR
//  - Reset: queue empty, pointers 0, out_valid 0, all bundle outputs 0; in_ready = 1 after reset.
//  - Queue: push on in_valid & in_ready; in_ready = (count != DEPTH) only — no push-when-full
//    even if a pop occurs the same cycle. Pointers wrap modulo DEPTH; simultaneous push/pop
//    keeps count unchanged.
//  - Decode is combinational on queue head. Output register loads when head present,
//    (!out_valid | out_ready), no hazard; the head pops on the same edge. Minimum latency:
//    push at edge N -> out_valid at edge N+1. Bundle held stable while out_valid & !out_ready.
//  - If out_valid & out_ready and queue empty: out_valid <= 0.
//  - Supported: R-type ADD ADDU SUB SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA SLLV SRLV SRAV JR;
//    ADDI ADDIU ORI XORI LUI LW SW BEQ BNE SLTI SLTIU J JAL. LUI: mem_rd=0, ext_imm={imm,16'h0}.
//    ORI/XORI zero-extend; others sign-extend.
//  - illegal=1 for any other opcode/func: reg_wr=mem_rd=mem_wr=jump=0, branch=00; still issued.
//  - reg_wr forced 0 when wr_addr == 0. JAL writes r31.
//  - Load-use (LU_STALL=1): held bundle has mem_rd & reg_wr & wr_addr != 0, is being accepted
//    (out_ready), and head reads it (rs always; rt for R-type, BEQ, BNE, SW) -> load bubble
//    (out_valid <= 0), head not popped. Following cycle it issues normally: exactly one bubble.
//  - flush: next edge count=0, out_valid=0; push in that cycle is dropped; flush dominates
//    push/pop/hazard. in_ready not gated by flush.
//  - Mid-operation reset: queue and bundle cleared immediately, no partial outputs.
// TESTING
//  1 addi $1,$0,5 (0x20010005) pc 0x0 -> next cycle out_valid=1, wr_addr=1, ext_imm=5, use_imm=1, reg_wr=1.
//  2 lw $2,0($1) (0x8C220000) then add $3,$2,$1 (0x00411820), out_ready=1 -> lw, one bubble, add.
//  3 lui $1,0x1234 (0x3C011234) -> ext_imm=0x12340000, mem_rd=0; beq 0x1022FFFF pc 0x10 -> branch=10, branch_pc=0x10.
//  4 j (0x08000040) pc 0x00400000 -> jump=1, jump_pc=0x00000100; opcode 0x3F -> illegal=1, reg_wr=0.
//  5 out_ready=0, push DEPTH+1 words -> in_ready=0 after DEPTH+1 accepted (DEPTH queued + bundle); order preserved.
//  6 flush with queue full and in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed word lost.

Source files
------------

// File: rtl/id_stage_queue.sv
// -----------------------------------------------------------------------------
// id_stage_queue
//   MIPS decode stage. Fetch pushes {instruction, pc} into a DEPTH-entry FIFO;
//   the FIFO head is decoded combinationally and captured into a registered
//   bundle offered to EX. Both sides use valid/ready handshakes.
//   Also provides a one-bubble load-use interlock, illegal-instruction
//   flagging, jump and branch target computation, and flush.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 drop queue contents and the output bundle
//   in_valid/in_ready     fetch handshake; in_ins / in_pc carry the word
//   out_valid/out_ready   EX handshake
//   out_pc                pc of the bundle
//   rd_addr_a/rd_addr_b   rs / rt
//   wr_addr, reg_wr       destination register and its write enable
//   mem_rd, mem_wr        load / store
//   aluop, sign           ALU operation, signed compare/shift/overflow
//   ext_imm, use_imm      extended immediate (shamt for R-type), operand select
//   jump, jump_pc         J/JAL and its target
//   branch, branch_pc     00 none, 01 jr, 10 beq, 11 bne and the branch target
//   illegal               unsupported opcode/func (still issued as a no-op)
// -----------------------------------------------------------------------------
package mips_def_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10    // result is operand B (already shifted immediate)
    } aluop_t;
endpackage

module id_stage_queue
    import mips_def_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 32,
    parameter int LU_STALL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rd_addr_a,
    output logic [4:0]      rd_addr_b,
    output logic [4:0]      wr_addr,
    output logic            reg_wr,
    output logic            mem_rd,
    output logic            mem_wr,
    output aluop_t          aluop,
    output logic            sign,
    output logic [31:0]     ext_imm,
    output logic            use_imm,
    output logic            jump,
    output logic [PC_W-1:0] jump_pc,
    output logic [1:0]      branch,
    output logic [PC_W-1:0] branch_pc,
    output logic            illegal
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      wr;
        logic            reg_wr;
        logic            mem_rd;
        logic            mem_wr;
        aluop_t          aluop;
        logic            sign;
        logic [31:0]     ext_imm;
        logic            use_imm;
        logic            jump;
        logic [PC_W-1:0] jump_pc;
        logic [1:0]      branch;
        logic [PC_W-1:0] branch_pc;
        logic            illegal;
    } bundle_t;

    logic [31:0]     ins_mem_q [DEPTH];
    logic [PC_W-1:0] pc_mem_q  [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic            out_valid_q, out_valid_d;
    bundle_t         bundle_q, bundle_d;

    logic [31:0]     head_ins_s;
    logic [PC_W-1:0] head_pc_s;
    logic            head_valid_s;
    logic            in_ready_s;
    logic            push_s;
    logic            load_s;
    logic            hazard_s;
    logic            head_reads_s;
    logic            reads_rt_s;
    logic            writes_s;
    bundle_t         dec_s;

    logic [5:0]      op_s;
    logic [5:0]      func_s;
    logic [4:0]      rs_s;
    logic [4:0]      rt_s;
    logic [4:0]      rd_s;
    logic [4:0]      shamt_s;
    logic [15:0]     imm_s;
    logic [PC_W-1:0] br_off_s;

    assign head_ins_s   = ins_mem_q[rd_ptr_q];
    assign head_pc_s    = pc_mem_q[rd_ptr_q];
    assign head_valid_s = (count_q != {CNT_W{1'b0}});
    assign in_ready_s   = (count_q != CNT_W'(DEPTH));

    assign op_s     = head_ins_s[31:26];
    assign rs_s     = head_ins_s[25:21];
    assign rt_s     = head_ins_s[20:16];
    assign rd_s     = head_ins_s[15:11];
    assign shamt_s  = head_ins_s[10:6];
    assign func_s   = head_ins_s[5:0];
    assign imm_s    = head_ins_s[15:0];
    assign br_off_s = {{(PC_W-18){imm_s[15]}}, imm_s, 2'b00};

    // Decode the queue head into a bundle.
    always_comb begin
        dec_s           = '0;
        writes_s        = 1'b0;
        dec_s.pc        = head_pc_s;
        dec_s.rs        = rs_s;
        dec_s.rt        = rt_s;
        dec_s.aluop     = ALU_ADD;
        dec_s.ext_imm   = (op_s == 6'h00) ? {27'd0, shamt_s} : {{16{imm_s[15]}}, imm_s};
        dec_s.jump_pc   = {head_pc_s[PC_W-1:28], head_ins_s[25:0], 2'b00};
        dec_s.branch_pc = head_pc_s + PC_W'(32'd4) + br_off_s;
        case (op_s)
            6'h00: begin
                dec_s.wr = rd_s;
                writes_s = 1'b1;
                case (func_s)
                    6'h20: begin dec_s.aluop = ALU_ADD; dec_s.sign = 1'b1; end
                    6'h21: dec_s.aluop = ALU_ADD;
                    6'h22: begin dec_s.aluop = ALU_SUB; dec_s.sign = 1'b1; end
                    6'h23: dec_s.aluop = ALU_SUB;
                    6'h24: dec_s.aluop = ALU_AND;
                    6'h25: dec_s.aluop = ALU_OR;
                    6'h26: dec_s.aluop = ALU_XOR;
                    6'h27: dec_s.aluop = ALU_NOR;
                    6'h2A: begin dec_s.aluop = ALU_SLT; dec_s.sign = 1'b1; end
                    6'h2B: dec_s.aluop = ALU_SLT;
                    6'h00: begin dec_s.aluop = ALU_SLL; dec_s.use_imm = 1'b1; end
                    6'h02: begin dec_s.aluop = ALU_SRL; dec_s.use_imm = 1'b1; end
                    6'h03: begin dec_s.aluop = ALU_SRA; dec_s.use_imm = 1'b1; dec_s.sign = 1'b1; end
                    6'h04: dec_s.aluop = ALU_SLL;
                    6'h06: dec_s.aluop = ALU_SRL;
                    6'h07: begin dec_s.aluop = ALU_SRA; dec_s.sign = 1'b1; end
                    6'h08: begin dec_s.branch = 2'b01; dec_s.wr = 5'd0; writes_s = 1'b0; end
                    default: begin dec_s.illegal = 1'b1; dec_s.wr = 5'd0; writes_s = 1'b0; end
                endcase
            end
            6'h08: begin dec_s.sign = 1'b1; dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1; end
            6'h09: begin dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1; end
            6'h0D: begin
                dec_s.aluop   = ALU_OR;
                dec_s.ext_imm = {16'h0000, imm_s};
                dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1;
            end
            6'h0E: begin
                dec_s.aluop   = ALU_XOR;
                dec_s.ext_imm = {16'h0000, imm_s};
                dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1;
            end
            6'h0F: begin
                dec_s.aluop   = ALU_LUI;
                dec_s.ext_imm = {imm_s, 16'h0000};
                dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1;
            end
            6'h0A: begin
                dec_s.aluop = ALU_SLT; dec_s.sign = 1'b1;
                dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1;
            end
            6'h0B: begin
                dec_s.aluop = ALU_SLT;
                dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1;
            end
            6'h23: begin dec_s.mem_rd = 1'b1; dec_s.use_imm = 1'b1; dec_s.wr = rt_s; writes_s = 1'b1; end
            6'h2B: begin dec_s.mem_wr = 1'b1; dec_s.use_imm = 1'b1; end
            6'h04: begin dec_s.aluop = ALU_SUB; dec_s.branch = 2'b10; end
            6'h05: begin dec_s.aluop = ALU_SUB; dec_s.branch = 2'b11; end
            6'h02: dec_s.jump = 1'b1;
            6'h03: begin dec_s.jump = 1'b1; dec_s.wr = 5'd31; writes_s = 1'b1; end
            default: dec_s.illegal = 1'b1;
        endcase
        // Writes to r0 are architecturally dropped.
        dec_s.reg_wr = writes_s & (dec_s.wr != 5'd0);
    end

    // Load-use detection: the held bundle is a load leaving this cycle and the head needs its result.
    always_comb begin
        reads_rt_s   = (op_s == 6'h00) || (op_s == 6'h04) || (op_s == 6'h05) || (op_s == 6'h2B);
        head_reads_s = (rs_s == bundle_q.wr) || (reads_rt_s && (rt_s == bundle_q.wr));
        hazard_s     = (LU_STALL != 0) && out_valid_q && out_ready && bundle_q.mem_rd &&
                       bundle_q.reg_wr && (bundle_q.wr != 5'd0) && head_valid_s && head_reads_s;
    end

    // Queue pointers, occupancy and output bundle next-state; flush overrides everything.
    always_comb begin
        push_s      = in_valid && in_ready_s && !flush;
        load_s      = head_valid_s && (!out_valid_q || out_ready) && !hazard_s && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        bundle_d    = bundle_q;
        if (flush) begin
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            count_d     = {CNT_W{1'b0}};
            out_valid_d = 1'b0;
            bundle_d    = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (load_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, load_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // A bubble (hazard) or a drained queue leaves out_valid low after acceptance.
            if (load_s) begin
                out_valid_d = 1'b1;
                bundle_d    = dec_s;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
        end
    end

    // Control and bundle registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    // Queue storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ins_mem_q[i] <= 32'd0;
                pc_mem_q[i]  <= {PC_W{1'b0}};
            end
        end else if (push_s) begin
            ins_mem_q[wr_ptr_q] <= in_ins;
            pc_mem_q[wr_ptr_q]  <= in_pc;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_pc    = bundle_q.pc;
    assign rd_addr_a = bundle_q.rs;
    assign rd_addr_b = bundle_q.rt;
    assign wr_addr   = bundle_q.wr;
    assign reg_wr    = bundle_q.reg_wr;
    assign mem_rd    = bundle_q.mem_rd;
    assign mem_wr    = bundle_q.mem_wr;
    assign aluop     = bundle_q.aluop;
    assign sign      = bundle_q.sign;
    assign ext_imm   = bundle_q.ext_imm;
    assign use_imm   = bundle_q.use_imm;
    assign jump      = bundle_q.jump;
    assign jump_pc   = bundle_q.jump_pc;
    assign branch    = bundle_q.branch;
    assign branch_pc = bundle_q.branch_pc;
    assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage_queue.sv
// -----------------------------------------------------------------------------
// tb_id_stage_queue
//   Directed steps followed by randomized traffic. A reference model (a
//   SystemVerilog queue plus a table-driven decoder) predicts out_valid,
//   in_ready and the full decoded bundle each cycle.
// -----------------------------------------------------------------------------
module tb_id_stage_queue;
    import mips_def_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        aluop_t      aluop;
        logic        sign;
        logic [31:0] ext_imm;
        logic        use_imm;
        logic        jump;
        logic [31:0] jump_pc;
        logic [1:0]  branch;
        logic [31:0] branch_pc;
        logic        illegal;
    } bundle_t;

    // dest: 0 none, 1 rd, 2 rt, 3 r31.  immk: 0 sign-ext (shamt for R), 1 zero-ext, 2 upper.
    typedef struct packed {
        aluop_t     alu;
        logic       sgn;
        logic [1:0] dest;
        logic [1:0] immk;
        logic       ui;
        logic       mr;
        logic       mw;
        logic       jmp;
        logic [1:0] br;
    } prop_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_ins, in_pc, out_pc, ext_imm, jump_pc, branch_pc;
    logic [4:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic        reg_wr, mem_rd, mem_wr, sign, use_imm, jump, illegal;
    aluop_t      aluop;
    logic [1:0]  branch;
    bundle_t     dut_b;

    int          errors = 0;
    int          checks = 0;

    prop_t       props [int];
    int          keys [$];
    logic [63:0] mq [$];
    bundle_t     mb;
    bit          mv;

    always #5 clk = ~clk;

    id_stage_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .LU_STALL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
        .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .aluop(aluop),
        .sign(sign), .ext_imm(ext_imm), .use_imm(use_imm), .jump(jump),
        .jump_pc(jump_pc), .branch(branch), .branch_pc(branch_pc), .illegal(illegal)
    );

    always_comb begin
        dut_b           = '0;
        dut_b.pc        = out_pc;
        dut_b.rs        = rd_addr_a;
        dut_b.rt        = rd_addr_b;
        dut_b.wr        = wr_addr;
        dut_b.reg_wr    = reg_wr;
        dut_b.mem_rd    = mem_rd;
        dut_b.mem_wr    = mem_wr;
        dut_b.aluop     = aluop;
        dut_b.sign      = sign;
        dut_b.ext_imm   = ext_imm;
        dut_b.use_imm   = use_imm;
        dut_b.jump      = jump;
        dut_b.jump_pc   = jump_pc;
        dut_b.branch    = branch;
        dut_b.branch_pc = branch_pc;
        dut_b.illegal   = illegal;
    end

    function automatic prop_t mk(aluop_t a, logic s, logic [1:0] d, logic [1:0] ik, logic ui,
                                 logic mr, logic mw, logic j, logic [1:0] br);
        mk = '{alu: a, sgn: s, dest: d, immk: ik, ui: ui, mr: mr, mw: mw, jmp: j, br: br};
    endfunction

    // Key: R-type uses func, everything else 64 + opcode.
    function automatic int key_of(logic [31:0] ins);
        key_of = (ins[31:26] == 6'h00) ? int'(ins[5:0]) : 64 + int'(ins[31:26]);
    endfunction

    function automatic bundle_t ref_decode(logic [31:0] ins, logic [31:0] pc);
        bundle_t     b;
        prop_t       p;
        logic [31:0] sx;
        int          k;
        k  = key_of(ins);
        sx = {{16{ins[15]}}, ins[15:0]};
        b           = '0;
        b.pc        = pc;
        b.rs        = ins[25:21];
        b.rt        = ins[20:16];
        b.jump_pc   = {pc[31:28], ins[25:0], 2'b00};
        b.branch_pc = pc + 32'd4 + (sx << 2);
        b.ext_imm   = (ins[31:26] == 6'h00) ? {27'd0, ins[10:6]} : sx;
        b.aluop     = ALU_ADD;
        if (props.exists(k)) begin
            p = props[k];
            b.aluop   = p.alu;
            b.sign    = p.sgn;
            b.use_imm = p.ui;
            b.mem_rd  = p.mr;
            b.mem_wr  = p.mw;
            b.jump    = p.jmp;
            b.branch  = p.br;
            if (p.immk == 2'd1) b.ext_imm = {16'h0, ins[15:0]};
            if (p.immk == 2'd2) b.ext_imm = {ins[15:0], 16'h0};
            case (p.dest)
                2'd1:    b.wr = ins[15:11];
                2'd2:    b.wr = ins[20:16];
                2'd3:    b.wr = 5'd31;
                default: b.wr = 5'd0;
            endcase
            b.reg_wr = (p.dest != 2'd0) && (b.wr != 5'd0);
        end else begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    // Does the instruction read register r (rs always; rt for R-type, BEQ, BNE, SW)?
    function automatic bit reads_reg(logic [31:0] ins, logic [4:0] r);
        bit uses_rt;
        uses_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h04) ||
                  (ins[31:26] == 6'h05) || (ins[31:26] == 6'h2B);
        return (ins[25:21] == r) || (uses_rt && (ins[20:16] == r));
    endfunction

    // Advance the reference by one clock using the inputs currently applied.
    task automatic model_step();
        bit acc, haz;
        if (flush) begin
            mq.delete();
            mv = 1'b0;
            mb = '0;
        end else begin
            acc = in_valid && (mq.size() != DEPTH);
            haz = 1'b0;
            if (mv && out_ready && mq.size() > 0 && mb.mem_rd && mb.reg_wr && mb.wr != 5'd0)
                haz = reads_reg(mq[0][31:0], mb.wr);
            if (mq.size() > 0 && (!mv || out_ready) && !haz) begin
                mb = ref_decode(mq[0][31:0], mq[0][63:32]);
                void'(mq.pop_front());
                mv = 1'b1;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            if (acc) mq.push_back({in_pc, in_ins});
        end
    endtask

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("out_valid", 256'(out_valid), 256'(mv));
        chk("in_ready", 256'(in_ready), 256'(mq.size() != DEPTH));
        if (mv) chk("bundle", 256'(dut_b), 256'(mb));
    endtask

    task automatic offer(logic [31:0] ins, logic [31:0] pc);
        in_valid = 1'b1;
        in_ins   = ins;
        in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        int          k;
        w = $urandom();
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) begin
            w[31:26] = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h20;
        end else begin
            k = keys[$urandom_range(0, keys.size() - 1)];
            if (k < 64) begin
                w[31:26] = 6'h00;
                w[5:0]   = 6'(k);
            end else begin
                w[31:26] = 6'(k - 64);
            end
        end
        return w;
    endfunction

    initial begin
        props[32'h20] = mk(ALU_ADD, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h21] = mk(ALU_ADD, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h22] = mk(ALU_SUB, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h23] = mk(ALU_SUB, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h24] = mk(ALU_AND, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h25] = mk(ALU_OR,  0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h26] = mk(ALU_XOR, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h27] = mk(ALU_NOR, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h2A] = mk(ALU_SLT, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h2B] = mk(ALU_SLT, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h00] = mk(ALU_SLL, 0, 1, 0, 1, 0, 0, 0, 2'b00);
        props[32'h02] = mk(ALU_SRL, 0, 1, 0, 1, 0, 0, 0, 2'b00);
        props[32'h03] = mk(ALU_SRA, 1, 1, 0, 1, 0, 0, 0, 2'b00);
        props[32'h04] = mk(ALU_SLL, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h06] = mk(ALU_SRL, 0, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h07] = mk(ALU_SRA, 1, 1, 0, 0, 0, 0, 0, 2'b00);
        props[32'h08] = mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 2'b01);
        props[64+8]   = mk(ALU_ADD, 1, 2, 0, 1, 0, 0, 0, 2'b00);
        props[64+9]   = mk(ALU_ADD, 0, 2, 0, 1, 0, 0, 0, 2'b00);
        props[64+13]  = mk(ALU_OR,  0, 2, 1, 1, 0, 0, 0, 2'b00);
        props[64+14]  = mk(ALU_XOR, 0, 2, 1, 1, 0, 0, 0, 2'b00);
        props[64+15]  = mk(ALU_LUI, 0, 2, 2, 1, 0, 0, 0, 2'b00);
        props[64+35]  = mk(ALU_ADD, 0, 2, 0, 1, 1, 0, 0, 2'b00);
        props[64+43]  = mk(ALU_ADD, 0, 0, 0, 1, 0, 1, 0, 2'b00);
        props[64+4]   = mk(ALU_SUB, 0, 0, 0, 0, 0, 0, 0, 2'b10);
        props[64+5]   = mk(ALU_SUB, 0, 0, 0, 0, 0, 0, 0, 2'b11);
        props[64+10]  = mk(ALU_SLT, 1, 2, 0, 1, 0, 0, 0, 2'b00);
        props[64+11]  = mk(ALU_SLT, 0, 2, 0, 1, 0, 0, 0, 2'b00);
        props[64+2]   = mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 1, 2'b00);
        props[64+3]   = mk(ALU_ADD, 0, 3, 0, 0, 0, 0, 1, 2'b00);
        foreach (props[k]) keys.push_back(k);

        // Reset
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ins = 32'd0; in_pc = 32'd0;
        mv = 1'b0; mb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
        chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
        chk("rst_bundle", 256'(dut_b), 256'(0));
        rst_n = 1'b1;

        // 1: addi $1,$0,5
        out_ready = 1'b1;
        offer(32'h20010005, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("t1_latency_low", 256'(out_valid), 256'(1'b0));
        tick();
        chk("t1_valid", 256'(out_valid), 256'(1'b1));
        chk("t1_wr_addr", 256'(wr_addr), 256'(5'd1));
        chk("t1_ext_imm", 256'(ext_imm), 256'(32'd5));
        chk("t1_use_imm", 256'(use_imm), 256'(1'b1));
        chk("t1_reg_wr", 256'(reg_wr), 256'(1'b1));
        tick();

        // 2: lw then dependent add -> exactly one bubble
        offer(32'h8C220000, 32'h4);
        tick();
        offer(32'h00411820, 32'h8);
        tick();
        in_valid = 1'b0;
        chk("t2_lw_valid", 256'(out_valid), 256'(1'b1));
        chk("t2_lw_mem_rd", 256'(mem_rd), 256'(1'b1));
        tick();
        chk("t2_bubble", 256'(out_valid), 256'(1'b0));
        tick();
        chk("t2_add_valid", 256'(out_valid), 256'(1'b1));
        chk("t2_add_pc", 256'(out_pc), 256'(32'h8));
        chk("t2_add_wr", 256'(wr_addr), 256'(5'd3));
        tick();

        // 3: lui, then beq with backward offset
        offer(32'h3C011234, 32'hC);
        tick();
        offer(32'h1022FFFF, 32'h10);
        tick();
        in_valid = 1'b0;
        chk("t3_lui_imm", 256'(ext_imm), 256'(32'h12340000));
        chk("t3_lui_mem_rd", 256'(mem_rd), 256'(1'b0));
        tick();
        chk("t3_beq_branch", 256'(branch), 256'(2'b10));
        chk("t3_beq_target", 256'(branch_pc), 256'(32'h10));
        tick();

        // 4: j and an illegal opcode
        offer(32'h08000040, 32'h00400000);
        tick();
        offer(32'hFC000000, 32'h00400004);
        tick();
        in_valid = 1'b0;
        chk("t4_jump", 256'(jump), 256'(1'b1));
        chk("t4_jump_pc", 256'(jump_pc), 256'(32'h00000100));
        tick();
        chk("t4_illegal", 256'(illegal), 256'(1'b1));
        chk("t4_ill_reg_wr", 256'(reg_wr), 256'(1'b0));
        tick();

        // 5: fill with EX stalled; DEPTH queued plus one held bundle
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            offer(32'h20000000 | (32'(i + 1) << 16) | 32'(i), 32'h100 + 32'(4 * i));
            tick();
        end
        chk("t5_full", 256'(in_ready), 256'(1'b0));
        offer(32'h20050077, 32'h200);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            chk("t5_order", 256'(out_pc), 256'(32'h100 + 32'(4 * i)));
            tick();
        end
        tick();

        // 6: flush while full with a push offered
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            offer(32'h24000000 | (32'(i + 1) << 16), 32'h300 + 32'(4 * i));
            tick();
        end
        flush = 1'b1;
        offer(32'h20090009, 32'h400);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t6_out_valid", 256'(out_valid), 256'(1'b0));
        chk("t6_in_ready", 256'(in_ready), 256'(1'b1));
        tick();
        tick();
        chk("t6_word_lost", 256'(out_valid), 256'(1'b0));

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            in_ins    = rand_ins();
            in_pc     = {$urandom()} & 32'hFFFF_FFFC;
            tick();
        end

        // Reset in the middle of a cycle with traffic in flight
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_ins = rand_ins();
            in_pc  = 32'h500 + 32'(4 * i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(out_valid), 256'(1'b0));
        chk("mid_rst_ready", 256'(in_ready), 256'(1'b1));
        chk("mid_rst_bundle", 256'(dut_b), 256'(0));
        mq.delete(); mv = 1'b0; mb = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(32'h2002000C, 32'h600);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_rst_issue", 256'(out_pc), 256'(32'h600));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
